// File: rtl/game_sequencer_if.sv
// Game-flow bus between the VGA game top level and the sequencer.
// The sequencer is the slave: it takes the start button and player status
// and returns the phase, stage counters and the stage-reload pulse.
interface game_sequencer_if;
   logic       start_btn;
   logic [1:0] player_status;
   logic [2:0] game_status;
   logic [1:0] world;
   logic [2:0] level;
   logic [3:0] lives;
   logic       load_level;
   logic       hold_active;

   modport master (
      output start_btn,
      output player_status,
      input  game_status,
      input  world,
      input  level,
      input  lives,
      input  load_level,
      input  hold_active
   );

   modport slave (
      input  start_btn,
      input  player_status,
      output game_status,
      output world,
      output level,
      output lives,
      output load_level,
      output hold_active
   );
endinterface

// File: rtl/game_sequencer.sv
// Game-flow controller: start, play, level/world advance, life lost,
// lose and win phases. Owns the world/level/lives counters and pulses
// load_level whenever a stage has to be (re)configured.
//
// state        | meaning
// -------------+-----------------------------------------------------
// ST_START     | waiting for a start press (code 0)
// ST_PLAYING   | stage running, reacting to player status (code 1)
// ST_LEVEL_INC | banner after a passed level (code 2)
// ST_WORLD_INC | banner after a completed world (code 3)
// ST_LIFE_LOST | banner after a death with lives left (code 4)
// ST_LOSE      | out of lives, waiting for a press (code 5)
// ST_WIN       | last level of last world passed (code 6)
module game_sequencer #(
   parameter int LEVELS_PER_WORLD = 4,
   parameter int NUM_WORLDS       = 3,
   parameter int START_LIVES      = 3,
   parameter int MAX_LIVES        = 9,
   parameter int HOLD_CYCLES      = 100000000
) (
   input  logic             clk,
   input  logic             rst,
   game_sequencer_if.slave  bus
);

   typedef enum logic [2:0] {
      ST_START     = 3'd0,
      ST_PLAYING   = 3'd1,
      ST_LEVEL_INC = 3'd2,
      ST_WORLD_INC = 3'd3,
      ST_LIFE_LOST = 3'd4,
      ST_LOSE      = 3'd5,
      ST_WIN       = 3'd6
   } state_t;

   localparam int              HOLD_W     = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
   localparam logic [2:0]      LAST_LEVEL = 3'(LEVELS_PER_WORLD - 1);
   localparam logic [1:0]      LAST_WORLD = 2'(NUM_WORLDS - 1);
   localparam logic [3:0]      LIVES_INIT = 4'(START_LIVES);
   localparam logic [3:0]      LIVES_MAX  = 4'(MAX_LIVES);

   logic              r_sync1;
   logic              r_sync2;
   logic              r_prev;
   logic              w_start_edge;

   state_t            r_state;
   logic [1:0]        r_world;
   logic [2:0]        r_level;
   logic [3:0]        r_lives;
   logic              r_load_level;
   logic              r_hold_active;
   logic              r_armed;
   logic [HOLD_W-1:0] r_hold_cnt;

   // Bring the raw button into clk_sys and keep its last value for edge detect
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_prev  <= 1'b0;
      end else begin
         r_sync1 <= bus.start_btn;
         r_sync2 <= r_sync1;
         r_prev  <= r_sync2;
      end
   end

   assign w_start_edge = r_sync2 & ~r_prev;

   // Game-flow FSM with its counters and registered outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state       <= ST_START;
         r_world       <= 2'd0;
         r_level       <= 3'd0;
         r_lives       <= LIVES_INIT;
         r_load_level  <= 1'b0;
         r_hold_active <= 1'b0;
         r_armed       <= 1'b0;
         r_hold_cnt    <= '0;
      end else begin
         r_load_level <= 1'b0;
         case (r_state)
            ST_START: begin
               if (w_start_edge) begin
                  r_state      <= ST_PLAYING;
                  r_load_level <= 1'b1;
                  r_armed      <= 1'b0;
               end
            end

            ST_PLAYING: begin
               // A stale pass/die code left over from the banner must first
               // drop back to 0 before it can trigger anything again.
               if (!r_armed) begin
                  if (bus.player_status == 2'd0) begin
                     r_armed <= 1'b1;
                  end
               end else if (bus.player_status == 2'd1) begin
                  r_hold_cnt <= '0;
                  if (r_level < LAST_LEVEL) begin
                     r_level       <= r_level + 3'd1;
                     r_state       <= ST_LEVEL_INC;
                     r_hold_active <= 1'b1;
                  end else if (r_world < LAST_WORLD) begin
                     r_world       <= r_world + 2'd1;
                     r_level       <= 3'd0;
                     if (r_lives < LIVES_MAX) begin
                        r_lives <= r_lives + 4'd1;
                     end
                     r_state       <= ST_WORLD_INC;
                     r_hold_active <= 1'b1;
                  end else begin
                     r_state <= ST_WIN;
                  end
               end else if (bus.player_status == 2'd2) begin
                  r_hold_cnt <= '0;
                  if (r_lives > 4'd1) begin
                     r_lives       <= r_lives - 4'd1;
                     r_state       <= ST_LIFE_LOST;
                     r_hold_active <= 1'b1;
                  end else begin
                     r_lives <= 4'd0;
                     r_state <= ST_LOSE;
                  end
               end
            end

            ST_LEVEL_INC, ST_WORLD_INC, ST_LIFE_LOST: begin
               if (r_hold_cnt == HOLD_LAST) begin
                  r_hold_cnt    <= '0;
                  r_state       <= ST_PLAYING;
                  r_load_level  <= 1'b1;
                  r_hold_active <= 1'b0;
                  r_armed       <= 1'b0;
               end else begin
                  r_hold_cnt <= r_hold_cnt + 1'b1;
               end
            end

            ST_LOSE, ST_WIN: begin
               // Back to the title screen only; a second press starts play
               if (w_start_edge) begin
                  r_state    <= ST_START;
                  r_world    <= 2'd0;
                  r_level    <= 3'd0;
                  r_lives    <= LIVES_INIT;
                  r_hold_cnt <= '0;
                  r_armed    <= 1'b0;
               end
            end

            default: begin
               r_state       <= ST_START;
               r_hold_cnt    <= '0;
               r_hold_active <= 1'b0;
               r_armed       <= 1'b0;
            end
         endcase
      end
   end

   assign bus.game_status = r_state;
   assign bus.world       = r_world;
   assign bus.level       = r_level;
   assign bus.lives       = r_lives;
   assign bus.load_level  = r_load_level;
   assign bus.hold_active = r_hold_active;

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer with a short banner (4 cycles) and a
// low lives ceiling (4) so saturation is reachable within one game.
module tb_game_sequencer;

   typedef struct {
      logic       b;
      logic [1:0] ps;
      logic [2:0] gs;
      logic [1:0] w;
      logic [2:0] l;
      logic [3:0] lv;
      logic       ld;
      logic       ha;
   } vec_t;

   logic clk;
   logic rst_n;
   int   n_vec;
   int   n_err;
   vec_t tbl[$];

   game_sequencer_if gif ();

   game_sequencer #(
      .LEVELS_PER_WORLD (4),
      .NUM_WORLDS       (3),
      .START_LIVES      (3),
      .MAX_LIVES        (4),
      .HOLD_CYCLES      (4)
   ) dut (
      .clk (clk),
      .rst (rst_n),
      .bus (gif.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t mk(input int b, input int ps, input int gs, input int w,
                               input int l, input int lv, input int ld, input int ha);
      vec_t v;
      v.b  = 1'(b);
      v.ps = 2'(ps);
      v.gs = 3'(gs);
      v.w  = 2'(w);
      v.l  = 3'(l);
      v.lv = 4'(lv);
      v.ld = 1'(ld);
      v.ha = 1'(ha);
      return v;
   endfunction

   task automatic add(input int b, input int ps, input int gs, input int w,
                      input int l, input int lv, input int ld, input int ha);
      tbl.push_back(mk(b, ps, gs, w, l, lv, ld, ha));
   endtask

   task automatic add_n(input int n, input int b, input int ps, input int gs, input int w,
                        input int l, input int lv, input int ld, input int ha);
      for (int i = 0; i < n; i++) add(b, ps, gs, w, l, lv, ld, ha);
   endtask

   // arm, pass level (nl-1 -> nl), 4-cycle banner, reload
   task automatic lvl_up(input int w, input int nl, input int lv);
      add(0, 0, 1, w, nl - 1, lv, 0, 0);
      add(0, 1, 2, w, nl, lv, 0, 1);
      add_n(3, 0, 0, 2, w, nl, lv, 0, 1);
      add(0, 0, 1, w, nl, lv, 1, 0);
   endtask

   // arm, pass last level of world nw-1, banner, reload
   task automatic world_up(input int nw, input int lvb, input int lva);
      add(0, 0, 1, nw - 1, 3, lvb, 0, 0);
      add(0, 1, 3, nw, 0, lva, 0, 1);
      add_n(3, 0, 0, 3, nw, 0, lva, 0, 1);
      add(0, 0, 1, nw, 0, lva, 1, 0);
   endtask

   task automatic die(input int w, input int l, input int lvb);
      add(0, 0, 1, w, l, lvb, 0, 0);
      add(0, 2, 4, w, l, lvb - 1, 0, 1);
      add_n(3, 0, 0, 4, w, l, lvb - 1, 0, 1);
      add(0, 0, 1, w, l, lvb - 1, 1, 0);
   endtask

   task automatic check(input string name, input vec_t e);
      n_vec++;
      if (gif.game_status !== e.gs || gif.world !== e.w || gif.level !== e.l ||
          gif.lives !== e.lv || gif.load_level !== e.ld || gif.hold_active !== e.ha) begin
         n_err++;
         $display("FAIL %s: got gs=%0d w=%0d l=%0d lives=%0d ld=%0b ha=%0b, want gs=%0d w=%0d l=%0d lives=%0d ld=%0b ha=%0b",
                  name, gif.game_status, gif.world, gif.level, gif.lives, gif.load_level,
                  gif.hold_active, e.gs, e.w, e.l, e.lv, e.ld, e.ha);
      end
   endtask

   task automatic step(input int b, input int ps);
      gif.start_btn     = 1'(b);
      gif.player_status = 2'(ps);
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;

      // ---------------- table: one full game and restarts ----------------
      add_n(2, 0, 0, 0, 0, 0, 3, 0, 0);
      add_n(2, 1, 0, 0, 0, 0, 3, 0, 0);
      add(1, 0, 1, 0, 0, 3, 1, 0);
      add(1, 0, 1, 0, 0, 3, 0, 0);
      // pass with status held at 1 through the banner: no double advance
      add(0, 1, 2, 0, 1, 3, 0, 1);
      add_n(3, 0, 1, 2, 0, 1, 3, 0, 1);
      add(0, 1, 1, 0, 1, 3, 1, 0);
      add_n(3, 0, 1, 1, 0, 1, 3, 0, 0);
      lvl_up(0, 2, 3);
      lvl_up(0, 3, 3);
      world_up(1, 3, 4);
      lvl_up(1, 1, 4);
      lvl_up(1, 2, 4);
      lvl_up(1, 3, 4);
      world_up(2, 4, 4);
      die(2, 0, 4);
      lvl_up(2, 1, 3);
      lvl_up(2, 2, 3);
      lvl_up(2, 3, 3);
      add(0, 0, 1, 2, 3, 3, 0, 0);
      add(0, 1, 6, 2, 3, 3, 0, 0);
      add_n(2, 0, 2, 6, 2, 3, 3, 0, 0);
      add_n(2, 1, 0, 6, 2, 3, 3, 0, 0);
      add_n(2, 1, 0, 0, 0, 0, 3, 0, 0);
      add_n(3, 0, 0, 0, 0, 0, 3, 0, 0);
      add_n(2, 1, 0, 0, 0, 0, 3, 0, 0);
      add(1, 0, 1, 0, 0, 3, 1, 0);
      add(1, 0, 1, 0, 0, 3, 0, 0);
      add_n(3, 0, 0, 1, 0, 0, 3, 0, 0);
      add_n(4, 1, 0, 1, 0, 0, 3, 0, 0);
      die(0, 0, 3);
      die(0, 0, 2);
      add(0, 0, 1, 0, 0, 1, 0, 0);
      add(0, 2, 5, 0, 0, 0, 0, 0);
      add_n(2, 0, 1, 5, 0, 0, 0, 0, 0);
      add_n(2, 1, 0, 5, 0, 0, 0, 0, 0);
      add(1, 0, 0, 0, 0, 3, 0, 0);
      add_n(3, 0, 0, 0, 0, 0, 3, 0, 0);
      add_n(2, 1, 0, 0, 0, 0, 3, 0, 0);
      add(1, 0, 1, 0, 0, 3, 1, 0);
      add(0, 0, 1, 0, 0, 3, 0, 0);

      // ---------------- reset ----------------
      rst_n             = 1'b0;
      gif.start_btn     = 1'b0;
      gif.player_status = 2'd0;
      #12;
      check("reset", mk(0, 0, 0, 0, 0, 3, 0, 0));
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < tbl.size(); i++) begin
         step(tbl[i].b, tbl[i].ps);
         check($sformatf("vec%0d", i), tbl[i]);
      end

      // ---------------- reserved status 3 is ignored while armed ----------------
      for (int i = 0; i < 50; i++) begin
         step(0, 3);
         check($sformatf("st3_%0d", i), mk(0, 0, 1, 0, 0, 3, 0, 0));
      end
      step(0, 1);
      check("pass_after_st3", mk(0, 0, 2, 0, 1, 3, 0, 1));
      for (int i = 0; i < 3; i++) step(0, 0);
      step(0, 0);
      check("banner_exit", mk(0, 0, 1, 0, 1, 3, 1, 0));

      // ---------------- reset mid LIFE_LOST at hold count 2 ----------------
      step(0, 0);
      step(0, 2);
      check("life_lost", mk(0, 0, 4, 0, 1, 2, 0, 1));
      step(0, 0);
      step(0, 0);
      check("life_lost_cnt2", mk(0, 0, 4, 0, 1, 2, 0, 1));
      #2;
      rst_n = 1'b0;
      #1;
      check("async_reset", mk(0, 0, 0, 0, 0, 3, 0, 0));
      @(posedge clk);
      #1;
      check("reset_held", mk(0, 0, 0, 0, 0, 3, 0, 0));
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) step(0, 0);
      check("idle_after_reset", mk(0, 0, 0, 0, 0, 3, 0, 0));
      step(1, 0);
      step(1, 0);
      check("press_e1", mk(0, 0, 0, 0, 0, 3, 0, 0));
      step(1, 0);
      check("press_e2", mk(0, 0, 1, 0, 0, 3, 1, 0));
      step(0, 0);
      check("load_one_cycle", mk(0, 0, 1, 0, 0, 3, 0, 0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
